// File: rtl/rgb_pkg.sv
// Shared encodings for the RGB lamp generator and sequence monitor:
// lamp states, sample classes, monitor FSM states and error causes.
package rgb_pkg;

    // Lamp line encodings, ordered {red, green, blue}
    typedef enum logic [2:0] {
        LAMP_BLANK = 3'b000,
        LAMP_RED   = 3'b100,
        LAMP_GREEN = 3'b010,
        LAMP_BLUE  = 3'b001
    } lamp_t;

    typedef enum logic [2:0] {
        CLS_BLANK = 3'd0,
        CLS_R     = 3'd1,
        CLS_G     = 3'd2,
        CLS_B     = 3'd3,
        CLS_MULTI = 3'd4
    } sample_class_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GOT_R = 2'd1,
        ST_GOT_G = 2'd2,
        ST_GOT_B = 2'd3
    } mon_state_t;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_MULTI = 2'd1,
        ERR_ORDER = 2'd2,
        ERR_TRUNC = 2'd3
    } err_code_t;

    // Outcome of evaluating one sample against the current FSM state
    typedef struct packed {
        logic      hit_err;
        err_code_t cause;
        logic      done;
    } eval_t;

endpackage

// File: rtl/rgb_sample_classify.sv
// Combinational classifier: maps one {red,green,blue} sample to
// BLANK, R, G, B or MULTI.
module rgb_sample_classify
    import rgb_pkg::*;
(
    input  logic          red,
    input  logic          green,
    input  logic          blue,
    output sample_class_t cls_c
);

    logic [2:0] lamps;

    assign lamps = {red, green, blue};

    always_comb begin
        cls_c = CLS_MULTI;
        case (lamps)
            LAMP_BLANK: cls_c = CLS_BLANK;
            LAMP_RED:   cls_c = CLS_R;
            LAMP_GREEN: cls_c = CLS_G;
            LAMP_BLUE:  cls_c = CLS_B;
            default:    cls_c = CLS_MULTI;
        endcase
    end

endmodule

// File: rtl/rgb_seq_monitor.sv
// Monitors R-G-B-blank lamp sequences, counts completions and flags protocol errors.
// Optional: define RGB_SEQ_MONITOR_ERRCNT_EN to add a saturating err_count output.
module rgb_seq_monitor
    import rgb_pkg::*;
#(
    parameter int unsigned COUNT_W = 8
)
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               red,
    input  logic               green,
    input  logic               blue,
    input  logic               err_clr,
    output logic               seq_done,
    output logic [COUNT_W-1:0] seq_count,
    output logic               err,
    output logic [1:0]         err_code
`ifdef RGB_SEQ_MONITOR_ERRCNT_EN
    ,
    output logic [7:0]         err_count
`endif
);

    sample_class_t      cls_c;
    mon_state_t         state;
    mon_state_t         state_nxt;
    eval_t              ev;
    logic               seq_done_nxt;
    logic [COUNT_W-1:0] seq_count_nxt;
    logic               err_nxt;
    logic [1:0]         err_code_nxt;

`ifdef RGB_SEQ_MONITOR_ERRCNT_EN
    localparam int unsigned ERR_COUNT_W   = 8;
    localparam logic [7:0]  ERR_COUNT_MAX = 8'hFF;
    logic [ERR_COUNT_W-1:0] err_count_nxt;
`endif

    rgb_sample_classify u_classify (
        .red   (red),
        .green (green),
        .blue  (blue),
        .cls_c (cls_c)
    );

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            seq_done  <= 1'b0;
            seq_count <= '0;
            err       <= 1'b0;
            err_code  <= 2'(ERR_NONE);
`ifdef RGB_SEQ_MONITOR_ERRCNT_EN
            err_count <= '0;
`endif
        end else begin
            state     <= state_nxt;
            seq_done  <= seq_done_nxt;
            seq_count <= seq_count_nxt;
            err       <= err_nxt;
            err_code  <= err_code_nxt;
`ifdef RGB_SEQ_MONITOR_ERRCNT_EN
            err_count <= err_count_nxt;
`endif
        end
    end

    // Next-state and next-output logic; MULTI outranks every other cause
    always_comb begin
        state_nxt     = state;
        ev.hit_err    = 1'b0;
        ev.cause      = ERR_NONE;
        ev.done       = 1'b0;
        seq_done_nxt  = 1'b0;
        seq_count_nxt = seq_count;
        err_nxt       = err;
        err_code_nxt  = err_code;
`ifdef RGB_SEQ_MONITOR_ERRCNT_EN
        err_count_nxt = err_count;
`endif

        if (cls_c == CLS_MULTI) begin
            ev.hit_err = 1'b1;
            ev.cause   = ERR_MULTI;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cls_c == CLS_R) begin
                        state_nxt = ST_GOT_R;
                    end else if (cls_c != CLS_BLANK) begin
                        ev.hit_err = 1'b1;
                        ev.cause   = ERR_ORDER;
                    end
                end
                ST_GOT_R: begin
                    if (cls_c == CLS_G) begin
                        state_nxt = ST_GOT_G;
                    end else begin
                        ev.hit_err = 1'b1;
                        ev.cause   = (cls_c == CLS_BLANK) ? ERR_TRUNC : ERR_ORDER;
                    end
                end
                ST_GOT_G: begin
                    if (cls_c == CLS_B) begin
                        state_nxt = ST_GOT_B;
                    end else begin
                        ev.hit_err = 1'b1;
                        ev.cause   = (cls_c == CLS_BLANK) ? ERR_TRUNC : ERR_ORDER;
                    end
                end
                ST_GOT_B: begin
                    if (cls_c == CLS_BLANK) begin
                        state_nxt = ST_IDLE;
                        ev.done   = 1'b1;
                    end else begin
                        ev.hit_err = 1'b1;
                        ev.cause   = ERR_ORDER;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end

        // The offending sample is discarded, never reused as a new start
        if (ev.hit_err) begin
            state_nxt = ST_IDLE;
        end

        seq_done_nxt  = ev.done;
        seq_count_nxt = seq_count + COUNT_W'(ev.done);

        // A same-cycle error wins over err_clr
        if (ev.hit_err) begin
            err_nxt      = 1'b1;
            err_code_nxt = 2'(ev.cause);
`ifdef RGB_SEQ_MONITOR_ERRCNT_EN
            if (err_clr) begin
                err_count_nxt = ERR_COUNT_W'(1);
            end else if (err_count != ERR_COUNT_MAX) begin
                err_count_nxt = err_count + ERR_COUNT_W'(1);
            end
`endif
        end else if (err_clr) begin
            err_nxt      = 1'b0;
            err_code_nxt = 2'(ERR_NONE);
`ifdef RGB_SEQ_MONITOR_ERRCNT_EN
            err_count_nxt = '0;
`endif
        end
    end

endmodule

// File: tb/tb_rgb_seq_monitor.sv
// Self-checking bench for rgb_seq_monitor: directed scenarios followed by
// randomized samples compared against a prefix-matching reference model.
module tb_rgb_seq_monitor;

    localparam int unsigned CW = 2;

    localparam logic [2:0] C_K = 3'b000;
    localparam logic [2:0] C_R = 3'b100;
    localparam logic [2:0] C_G = 3'b010;
    localparam logic [2:0] C_B = 3'b001;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          red;
    logic          green;
    logic          blue;
    logic          err_clr;
    logic          seq_done;
    logic [CW-1:0] seq_count;
    logic          err;
    logic [1:0]    err_code;
`ifdef RGB_SEQ_MONITOR_ERRCNT_EN
    logic [7:0]    err_count;
`endif

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: how much of the R,G,B,blank pattern has been matched
    logic [2:0] want [4];
    int m_pos;
    int m_cnt;
    int m_ecnt;
    int m_code;
    bit m_done;
    bit m_err;

    rgb_seq_monitor #(.COUNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .red       (red),
        .green     (green),
        .blue      (blue),
        .err_clr   (err_clr),
        .seq_done  (seq_done),
        .seq_count (seq_count),
        .err       (err),
        .err_code  (err_code)
`ifdef RGB_SEQ_MONITOR_ERRCNT_EN
        ,
        .err_count (err_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("seq_done",  8'(seq_done),  8'(m_done));
        check("seq_count", 8'(seq_count), 8'(m_cnt));
        check("err",       8'(err),       8'(m_err));
        check("err_code",  8'(err_code),  8'(m_code));
`ifdef RGB_SEQ_MONITOR_ERRCNT_EN
        check("err_count", err_count,     8'(m_ecnt));
`endif
    endtask

    function automatic void model_reset();
        m_pos  = 0;
        m_cnt  = 0;
        m_ecnt = 0;
        m_code = 0;
        m_done = 1'b0;
        m_err  = 1'b0;
    endfunction

    function automatic void model_step(input logic [2:0] s, input logic clr);
        bit bad  = 1'b0;
        int code = 0;
        m_done = 1'b0;
        if ($countones(s) >= 2) begin
            bad  = 1'b1;
            code = 1;
        end else if (m_pos == 0 && s == C_K) begin
            bad = 1'b0;
        end else if (s == want[m_pos]) begin
            m_pos++;
            if (m_pos == 4) begin
                m_pos  = 0;
                m_done = 1'b1;
                m_cnt  = (m_cnt + 1) % (1 << CW);
            end
        end else begin
            bad  = 1'b1;
            code = (s == C_K) ? 3 : 2;
        end
        if (bad) begin
            m_pos  = 0;
            m_err  = 1'b1;
            m_code = code;
            m_ecnt = clr ? 1 : ((m_ecnt < 255) ? m_ecnt + 1 : 255);
        end else if (clr) begin
            m_err  = 1'b0;
            m_code = 0;
            m_ecnt = 0;
        end
    endfunction

    task automatic step(input logic [2:0] s, input logic clr);
        @(negedge clk);
        {red, green, blue} = s;
        err_clr = clr;
        @(posedge clk);
        model_step(s, clr);
        #1 check_all();
    endtask

    // Asynchronous reset pulse landing between clock edges
    task automatic pulse_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_all();
        @(negedge clk);
        {red, green, blue} = C_K;
        err_clr = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic good_seq();
        step(C_R, 1'b0);
        step(C_G, 1'b0);
        step(C_B, 1'b0);
        step(C_K, 1'b0);
    endtask

    initial begin
        int s5_exp [5];
        logic [2:0] s;
        logic clr;
        int roll;

        s5_exp  = '{1, 2, 3, 0, 1};
        want[0] = C_R;
        want[1] = C_G;
        want[2] = C_B;
        want[3] = C_K;

        rst_n = 1'b0;
        {red, green, blue} = C_K;
        err_clr = 1'b0;
        model_reset();
        #12 check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Scenario 1: one clean sequence
        good_seq();
        check("s1_done", 8'(seq_done), 8'd1);
        check("s1_count", 8'(seq_count), 8'd1);
        step(C_K, 1'b0);
        check("s1_done_drop", 8'(seq_done), 8'd0);

        // Scenario 2: MULTI error, then monitoring continues with err held
        pulse_reset();
        step(C_R, 1'b0);
        step(C_R | C_G, 1'b0);
        check("s2_code", 8'(err_code), 8'd1);
        good_seq();
        check("s2_count", 8'(seq_count), 8'd1);
        check("s2_err_held", 8'(err), 8'd1);

        // Scenario 3: truncation, then clear
        pulse_reset();
        step(C_R, 1'b0);
        step(C_K, 1'b0);
        check("s3_code", 8'(err_code), 8'd3);
        step(C_K, 1'b1);
        check("s3_clr_err", 8'(err), 8'd0);

        // Scenario 4: trailing R is an ORDER error, not a new start
        pulse_reset();
        step(C_R, 1'b0);
        step(C_G, 1'b0);
        step(C_B, 1'b0);
        step(C_R, 1'b0);
        check("s4_code", 8'(err_code), 8'd2);
        step(C_G, 1'b0);
        step(C_B, 1'b0);
        step(C_K, 1'b0);
        check("s4_no_count", 8'(seq_count), 8'd0);

        // Scenario 5: counter wrap at COUNT_W=2
        pulse_reset();
        for (int k = 0; k < 5; k++) begin
            good_seq();
            check("s5_count", 8'(seq_count), 8'(s5_exp[k]));
        end

        // Scenario 6: reset in GOT_G abandons the partial sequence silently
        pulse_reset();
        step(C_R, 1'b0);
        step(C_G, 1'b0);
        pulse_reset();
        check("s6_reset_err", 8'(err), 8'd0);
        step(C_B, 1'b0);
        step(C_K, 1'b0);
        check("s6_code", 8'(err_code), 8'd2);
        step(C_G, 1'b1);
        check("s6_err_wins", 8'(err), 8'd1);

        // Randomized traffic, steered toward legal progress most of the time
        for (int i = 0; i < 600; i++) begin
            roll = int'($urandom_range(0, 99));
            if (roll < 2) begin
                pulse_reset();
            end else begin
                if (roll < 72) s = want[m_pos];
                else s = 3'($urandom_range(0, 7));
                clr = ($urandom_range(0, 9) == 0);
                step(s, clr);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
